matmul_4x4_stream_ctrl: RTL and testbench

MATMUL_4X4_STREAM_CTRL -- requirements
Module: matmul_4x4_stream_ctrl

---
 rtl/matmul_4x4_stream_ctrl.sv | 124 ++++++++++++
 tb/tb_matmul_4x4_stream_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_4x4_stream_ctrl.sv
// Streaming wrapper around an external NxN matrix multiplier: collects A then B,
// pulses the multiplier, captures its result and streams C out row-major.
module matmul_4x4_stream_ctrl #(
    parameter int BIT_PREC = 8,
    parameter int N        = 4
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [BIT_PREC-1:0]        in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [2*BIT_PREC:0]        out_data,
    output logic                              out_last,
    output logic                              busy,
    output logic [N*N*BIT_PREC-1:0]           mm_A,
    output logic [N*N*BIT_PREC-1:0]           mm_B,
    output logic                              mm_start,
    input  logic [N*N*(2*BIT_PREC+1)-1:0]     mm_C,
    input  logic                              mm_valid
);
    // state | meaning
    // LOAD  | accept operands  ; START | pulse mm_start ; WAIT | await mm_valid ; SEND | stream C

    localparam int NN = N * N;
    localparam int RW = 2 * BIT_PREC + 1;
    localparam int CW = $clog2(2 * NN);
    localparam int IW = $clog2(NN);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * NN - 1);
    localparam logic [CW-1:0] CNT_B    = CW'(NN);
    localparam logic [IW-1:0] IDX_LAST = IW'(NN - 1);

    typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_SEND} state_t;

    state_t state, state_nxt;

    logic signed [BIT_PREC-1:0] a_mem   [NN];
    logic signed [BIT_PREC-1:0] b_mem   [NN];
    logic signed [RW-1:0]       res_mem [NN];
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [IW-1:0] slot;
    logic          wait_armed;
    logic          accept;
    logic          capture;
    logic          xfer;

    assign accept  = (state == S_LOAD) && in_valid;
    assign capture = (state == S_WAIT) && wait_armed && mm_valid;
    assign xfer    = (state == S_SEND) && out_ready;
    assign slot    = (cnt < CNT_B) ? cnt[IW-1:0] : IW'(cnt - CNT_B);

    // wait_armed is low only during the first WAIT cycle, masking a stale mm_valid
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_LOAD;
            cnt        <= '0;
            idx        <= '0;
            wait_armed <= 1'b0;
            for (int k = 0; k < NN; k++) begin
                a_mem[k]   <= '0;
                b_mem[k]   <= '0;
                res_mem[k] <= '0;
            end
        end else begin
            state      <= state_nxt;
            wait_armed <= (state == S_WAIT);
            if (accept) begin
                if (cnt < CNT_B)
                    a_mem[slot] <= in_data;
                else
                    b_mem[slot] <= in_data;
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            end
            if (capture) begin
                for (int k = 0; k < NN; k++)
                    res_mem[k] <= mm_C[k*RW +: RW];
            end
            if (xfer)
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mm_start  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b1;
        case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && (cnt == CNT_LAST))
                    state_nxt = S_START;
            end
            S_START: begin
                mm_start  = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (wait_armed && mm_valid)
                    state_nxt = S_SEND;
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_last  = (idx == IDX_LAST);
                if (out_ready && (idx == IDX_LAST))
                    state_nxt = S_LOAD;
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    assign out_data = res_mem[idx];

    for (genvar g = 0; g < NN; g++) begin : g_flat
        assign mm_A[g*BIT_PREC +: BIT_PREC] = a_mem[g];
        assign mm_B[g*BIT_PREC +: BIT_PREC] = b_mem[g];
    end

endmodule

// File: tb/tb_matmul_4x4_stream_ctrl.sv
// Bench for matmul_4x4_stream_ctrl: behavioural multiplier attached, expected C
// computed from the streamed operands with plain integer arithmetic.
module tb_matmul_4x4_stream_ctrl;
    localparam int BP = 8;
    localparam int N  = 4;
    localparam int NN = N * N;
    localparam int RW = 2 * BP + 1;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic signed [BP-1:0]  in_data = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic signed [RW-1:0]  out_data;
    logic                  out_last;
    logic                  busy;
    logic [NN*BP-1:0]      mm_A;
    logic [NN*BP-1:0]      mm_B;
    logic                  mm_start;
    logic [NN*RW-1:0]      mm_C_r = '0;
    logic [NN*RW-1:0]      c_next = '0;
    logic                  mm_v_r = 1'b0;
    logic                  mm_noise = 1'b0;
    logic                  mm_valid;

    int errors = 0;
    int checks = 0;
    int ops   [2*NN];
    int exp_c [NN];
    int lat = 3;
    bit sticky = 1'b0;
    int cd = 0;
    bit pend = 1'b0;
    int start_pulses = 0;
    int xfers = 0;

    assign mm_valid = mm_v_r | mm_noise;

    always #5 clk = ~clk;

    matmul_4x4_stream_ctrl #(.BIT_PREC(BP), .N(N)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy),
        .mm_A(mm_A), .mm_B(mm_B), .mm_start(mm_start),
        .mm_C(mm_C_r), .mm_valid(mm_valid)
    );

    task automatic check(input string tag, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Behavioural multiplier: result appears lat cycles after mm_start.
    // In sticky mode mm_valid stays high with the old result until the update.
    always @(posedge clk) begin
        if (mm_start) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    int s;
                    s = 0;
                    for (int k = 0; k < N; k++)
                        s += int'($signed(mm_A[(r*N+k)*BP +: BP])) * int'($signed(mm_B[(k*N+c)*BP +: BP]));
                    c_next[(r*N+c)*RW +: RW] = RW'(s);
                end
            end
            pend <= 1'b1;
            cd   <= lat;
            if (!sticky) mm_v_r <= 1'b0;
        end else if (pend) begin
            if (cd <= 1) begin
                mm_C_r <= c_next;
                mm_v_r <= 1'b1;
                pend   <= 1'b0;
            end else begin
                cd <= cd - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (mm_start) start_pulses++;
        if (out_valid && out_ready) xfers++;
    end

    task automatic compute_exp();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                exp_c[r*N+c] = 0;
                for (int k = 0; k < N; k++)
                    exp_c[r*N+c] += ops[r*N+k] * ops[NN+k*N+c];
            end
    endtask

    task automatic ops_seq();
        for (int k = 0; k < 2*NN; k++) ops[k] = k + 1;
    endtask

    task automatic ops_rand();
        for (int k = 0; k < 2*NN; k++) ops[k] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        mm_noise = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_mm_start", mm_start, 0);
        check("rst_mm_A_zero", longint'(mm_A != '0), 0);
        check("rst_mm_B_zero", longint'(mm_B != '0), 0);
        check("rst_out_data", out_data, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);
        check("rel_busy", busy, 0);
    endtask

    task automatic feed(input bit toggle, input bit noise, input int limit);
        int k = 0;
        int guard = 0;
        bit ph = 1'b1;
        while (k < limit) begin
            @(negedge clk);
            guard++;
            if (guard > 500) begin
                check("feed_timeout", k, limit);
                break;
            end
            in_valid = toggle ? ph : 1'b1;
            ph = !ph;
            in_data = in_valid ? BP'(ops[k]) : BP'($urandom);
            mm_noise = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (in_valid && in_ready) k++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        mm_noise = 1'b0;
    endtask

    task automatic recv(input bit stall, input int limit);
        int i = 0;
        int guard = 0;
        int hold = 0;
        int base = xfers;
        while (i < limit) begin
            @(negedge clk);
            guard++;
            if (guard > 300) begin
                check("recv_timeout", i, limit);
                break;
            end
            if (stall && i == 5 && out_valid && hold < 3) begin
                out_ready = 1'b0;
                hold++;
            end else begin
                out_ready = stall ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            end
            if (out_valid) begin
                check($sformatf("out_data[%0d]", i), out_data, exp_c[i]);
                check($sformatf("out_last[%0d]", i), out_last, (i == NN - 1));
                if (out_ready) i++;
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        if (limit == NN) begin
            check("xfer_count", xfers - base, NN);
            check("done_out_valid", out_valid, 0);
            check("done_in_ready", in_ready, 1);
            check("done_busy", busy, 0);
        end
    endtask

    task automatic run_job(input bit toggle, input bit noise, input bit stall,
                           input int l, input bit stk, input int send_limit);
        int base;
        logic [NN*BP-1:0] ea;
        logic [NN*BP-1:0] eb;
        lat = l;
        sticky = stk;
        compute_exp();
        for (int k = 0; k < NN; k++) begin
            ea[k*BP +: BP] = BP'(ops[k]);
            eb[k*BP +: BP] = BP'(ops[NN+k]);
        end
        base = start_pulses;
        feed(toggle, noise, 2*NN);
        check("start_pulse", mm_start, 1);
        check("start_no_early", start_pulses, base);
        check("start_in_ready", in_ready, 0);
        check("start_busy", busy, 1);
        check("start_mm_A", longint'(mm_A == ea), 1);
        check("start_mm_B", longint'(mm_B == eb), 1);
        @(negedge clk);
        check("start_single", mm_start, 0);
        check("start_count", start_pulses, base + 1);
        check("wait_out_valid", out_valid, 0);
        recv(stall, send_limit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();

        ops_seq();
        run_job(1'b0, 1'b0, 1'b0, 3, 1'b0, NN);
        run_job(1'b1, 1'b0, 1'b0, 2, 1'b0, NN);

        for (int k = 0; k < 2*NN; k++) ops[k] = (k < NN) ? -128 : 127;
        run_job(1'b0, 1'b0, 1'b0, 4, 1'b0, NN);

        ops_rand();
        run_job(1'b0, 1'b0, 1'b1, 2, 1'b0, NN);

        ops_rand();
        run_job(1'b0, 1'b0, 1'b0, 1, 1'b1, NN);

        ops_rand();
        run_job(1'b1, 1'b1, 1'b0, 3, 1'b0, NN);

        ops_rand();
        feed(1'b0, 1'b0, 20);
        do_reset();
        ops_seq();
        run_job(1'b0, 1'b0, 1'b0, 3, 1'b0, NN);

        ops_rand();
        lat = 20;
        sticky = 1'b0;
        feed(1'b0, 1'b0, 2*NN);
        repeat (5) @(negedge clk);
        do_reset();
        ops_seq();
        run_job(1'b0, 1'b0, 1'b0, 3, 1'b0, NN);

        ops_rand();
        run_job(1'b0, 1'b0, 1'b0, 2, 1'b0, 5);
        do_reset();
        ops_seq();
        run_job(1'b0, 1'b0, 1'b0, 3, 1'b0, NN);

        for (int j = 0; j < 4; j++) begin
            ops_rand();
            run_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                    int'($urandom_range(1, 6)), 1'b0, NN);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
